// File: rtl/io_pwm_pkg.sv
// Shared definitions for the dma_io LED PWM block: register map and channel modes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package io_pwm_pkg;

  // Register word offsets relative to the block's base address
  localparam logic [13:0] OFS_CTRL     = 14'd0;
  localparam logic [13:0] OFS_PRESCALE = 14'd1;
  localparam logic [13:0] OFS_STATUS   = 14'd2;
  localparam logic [13:0] OFS_CH_BASE  = 14'd4;

  // Channel mode, CH_CFG[1:0]
  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_PWM   = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

endpackage

// File: rtl/io_led_pwm_if.sv
// dma_io bus slice seen by one read-chain member: write port plus read address / data chain.
// Latency: n/a (wires only).
// Backpressure: none; the bus has no stall signal.
//   master: CPU side, drives write strobe/address/data, read address and upstream read data.
//   slave : peripheral side, returns read data to the next chain member.
interface io_led_pwm_if;
  logic        we;
  logic [13:0] wadr;
  logic [15:0] wdata;
  logic [13:0] radr;
  logic [15:0] rdata_in;
  logic [15:0] rdata;

  modport master (
    output we, wadr, wdata, radr, rdata_in,
    input  rdata
  );

  modport slave (
    input  we, wadr, wdata, radr, rdata_in,
    output rdata
  );
endinterface

// File: rtl/io_pwm_chan.sv
// One LED channel: mode decode, PWM compare against the shared period counter, blink divider.
// Latency: state is combinational from config and counters; bcnt/bstate update on the clk edge.
// Backpressure: none.
//   in : clk, rst, tick, wrap, pcnt, en, clr, mode, duty
//   out: state (logical LED state, before any pin inversion)
module io_pwm_chan
  import io_pwm_pkg::*;
#(
  parameter int unsigned PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wrap,
  input  logic [PWM_W-1:0] pcnt,
  input  logic             en,
  input  logic             clr,
  input  mode_e            mode,
  input  logic [PWM_W-1:0] duty,
  output logic             state
);

  logic [PWM_W-1:0] bcnt;
  logic             bstate;
  logic             blink_step;

  // wrap is already qualified by tick; the blink divider only runs while in blink
  // mode so that leaving and re-entering blink resumes from the held phase.
  assign blink_step = tick & wrap & (mode == MODE_BLINK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt   <= '0;
      bstate <= 1'b0;
    end else if (clr) begin
      bcnt   <= '0;
      bstate <= 1'b0;
    end else if (blink_step) begin
      // Half-period is duty+1 PWM periods
      if (bcnt == duty) begin
        bcnt   <= '0;
        bstate <= ~bstate;
      end else begin
        bcnt   <= bcnt + PWM_W'(1);
      end
    end
  end

  always_comb begin
    state = 1'b0;
    if (en) begin
      case (mode)
        MODE_OFF:   state = 1'b0;
        MODE_ON:    state = 1'b1;
        MODE_PWM:   state = (pcnt < duty);
        MODE_BLINK: state = bstate;
        default:    state = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/io_led_pwm.sv
// Multi-channel LED driver on the dma_io bus: off/on/PWM/blink per channel from a shared prescaler.
// Latency: register write lands on the write edge; led_out reflects it one clk edge later.
// Backpressure: none; writes always accepted, reads are combinational with chain pass-through.
//   clk, rst : clock and asynchronous active-high reset
//   dma_io   : bus slave (write port, read address, read-data daisy chain)
//   led_out  : registered LED drive, NCH bits, inverted when ACTIVE_LOW
module io_led_pwm
  import io_pwm_pkg::*;
#(
  parameter int unsigned NCH        = 3,
  parameter int unsigned PWM_W      = 8,
  parameter logic [13:0] BASE_ADR   = 14'h3000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  io_led_pwm_if.slave    dma_io,
  output logic [NCH-1:0] led_out
);

  // ---------------- address decode ----------------
  logic [13:0] wr_off, rd_off;
  logic        wr_in_win, rd_in_win;
  logic        wr_ctrl, wr_pre;
  logic        clr;

  // Offsets are only meaningful at or above the base; the subtraction would
  // otherwise wrap an address below the window onto a mapped offset.
  assign wr_in_win = (dma_io.wadr >= BASE_ADR);
  assign rd_in_win = (dma_io.radr >= BASE_ADR);
  assign wr_off    = dma_io.wadr - BASE_ADR;
  assign rd_off    = dma_io.radr - BASE_ADR;

  assign wr_ctrl = dma_io.we & wr_in_win & (wr_off == OFS_CTRL);
  assign wr_pre  = dma_io.we & wr_in_win & (wr_off == OFS_PRESCALE);
  assign clr     = wr_ctrl & dma_io.wdata[1];

  // ---------------- global registers ----------------
  logic        en;
  logic [15:0] prescale;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en       <= 1'b0;
      prescale <= '0;
    end else begin
      if (wr_ctrl) en       <= dma_io.wdata[0];
      if (wr_pre)  prescale <= dma_io.wdata;
    end
  end

  // ---------------- prescaler and period counter ----------------
  logic [15:0]      pre_cnt;
  logic [PWM_W-1:0] pcnt;
  logic             tick, wrap;

  // >= rather than == so that shrinking PRESCALE below the running count
  // ticks immediately instead of waiting for a 16-bit rollover.
  assign tick = en & (pre_cnt >= prescale);
  assign wrap = tick & (pcnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      pcnt    <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
      pcnt    <= '0;
    end else begin
      if (tick)    pre_cnt <= '0;
      else if (en) pre_cnt <= pre_cnt + 16'd1;
      if (tick)    pcnt    <= pcnt + PWM_W'(1);
    end
  end

  // ---------------- channels ----------------
  logic [NCH-1:0]       ch_state;
  logic [NCH-1:0][15:0] ch_cfg_rd;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic             wr_cfg;
    mode_e            mode_q;
    logic [PWM_W-1:0] duty_q;

    assign wr_cfg = dma_io.we & wr_in_win & (wr_off == OFS_CH_BASE + 14'(ch));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode_q <= MODE_OFF;
        duty_q <= '0;
      end else if (wr_cfg) begin
        mode_q <= mode_e'(dma_io.wdata[1:0]);
        duty_q <= dma_io.wdata[PWM_W+7:8];
      end
    end

    // Only the stored fields read back; everything else is zero
    assign ch_cfg_rd[ch] = 16'({duty_q, 6'b0, mode_q});

    io_pwm_chan #(
      .PWM_W (PWM_W)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .wrap  (wrap),
      .pcnt  (pcnt),
      .en    (en),
      .clr   (clr),
      .mode  (mode_q),
      .duty  (duty_q),
      .state (ch_state[ch])
    );
  end

  // ---------------- read mux ----------------
  logic [15:0] status;
  logic [15:0] rdata;

  assign status = {8'(pcnt), 8'(ch_state)};

  always_comb begin
    rdata = dma_io.rdata_in;
    if (rd_in_win) begin
      if (rd_off == OFS_CTRL) begin
        rdata = {15'b0, en};
      end else if (rd_off == OFS_PRESCALE) begin
        rdata = prescale;
      end else if (rd_off == OFS_STATUS) begin
        rdata = status;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          if (rd_off == OFS_CH_BASE + 14'(i)) rdata = ch_cfg_rd[i];
        end
      end
    end
  end

  assign dma_io.rdata = rdata;

  // ---------------- output register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_out <= {NCH{ACTIVE_LOW}};
    else     led_out <= ch_state ^ {NCH{ACTIVE_LOW}};
  end

endmodule

// File: tb/tb_io_led_pwm.sv
// Directed bench for io_led_pwm: register table plus multi-cycle PWM/blink/prescale/enable sequences.
// Inputs change on the falling edge; outputs are sampled on the falling edge or shortly after.
// Runs NCH=3, PWM_W=8, ACTIVE_LOW=1, so a lit LED reads as 0 on led_out.
module tb_io_led_pwm;
  import io_pwm_pkg::*;

  localparam int          NCH   = 3;
  localparam int          PWM_W = 8;
  localparam logic [13:0] BASE  = 14'h3000;
  localparam logic [15:0] PASS  = 16'hA5A5;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] led_out;

  io_led_pwm_if bus ();

  io_led_pwm #(
    .NCH        (NCH),
    .PWM_W      (PWM_W),
    .BASE_ADR   (BASE),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dma_io  (bus),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [13:0] wadr;
    logic [15:0] wdata;
    logic [13:0] radr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_led(input string name, input logic [NCH-1:0] exp);
    chk16(name, 16'(led_out), 16'(exp));
  endtask

  // Call at a falling edge; returns at the falling edge after the write edge.
  task automatic wr_abs(input logic we, input logic [13:0] adr, input logic [15:0] d);
    bus.we    = we;
    bus.wadr  = adr;
    bus.wdata = d;
    @(posedge clk);
    @(negedge clk);
    bus.we    = 1'b0;
  endtask

  task automatic wr(input logic [13:0] off, input logic [15:0] d);
    wr_abs(1'b1, BASE + off, d);
  endtask

  task automatic rd(input string name, input logic [13:0] adr, input logic [15:0] exp);
    bus.radr = adr;
    #1;
    chk16(name, bus.rdata, exp);
  endtask

  initial begin
    int cnt;

    // ---- register-access vectors, applied from reset with EN=0 ----
    vecs[0]  = '{1'b1, BASE + 14'd1, 16'h1234, BASE + 14'd1, 16'h1234};  // PRESCALE r/w
    vecs[1]  = '{1'b0, BASE + 14'd1, 16'hBEEF, BASE + 14'd1, 16'h1234};  // we=0 ignored
    vecs[2]  = '{1'b1, BASE + 14'd4, 16'hFFFF, BASE + 14'd4, 16'hFF03};  // unused bits dropped
    vecs[3]  = '{1'b1, BASE + 14'd5, 16'h4202, BASE + 14'd5, 16'h4202};
    vecs[4]  = '{1'b1, BASE + 14'd6, 16'h0301, BASE + 14'd6, 16'h0301};
    vecs[5]  = '{1'b1, BASE + 14'd0, 16'hFFFE, BASE + 14'd0, 16'h0000};  // CLR reads 0
    vecs[6]  = '{1'b1, BASE + 14'd0, 16'h0001, BASE + 14'd0, 16'h0001};
    vecs[7]  = '{1'b1, BASE + 14'd0, 16'h0000, BASE + 14'd0, 16'h0000};
    vecs[8]  = '{1'b1, BASE + 14'd2, 16'hFFFF, BASE + 14'd2, 16'h0000};  // STATUS read-only
    vecs[9]  = '{1'b1, BASE + 14'd3, 16'h1111, BASE + 14'd3, PASS};      // hole in map
    vecs[10] = '{1'b1, BASE + 14'd7, 16'h2222, BASE + 14'd7, PASS};      // 4+NCH unmapped
    vecs[11] = '{1'b1, BASE - 14'd1, 16'h3333, BASE - 14'd1, PASS};      // below window
    vecs[12] = '{1'b0, BASE + 14'd5, 16'hFFFF, BASE + 14'd5, 16'h4202};  // we=0 ignored

    rst           = 1'b1;
    bus.we        = 1'b0;
    bus.wadr      = '0;
    bus.wdata     = '0;
    bus.radr      = '0;
    bus.rdata_in  = PASS;

    repeat (2) @(negedge clk);
    #1;
    chk_led("reset_led", 3'b111);
    rd("reset_status", BASE + 14'd2, 16'h0000);
    rd("reset_passthru", 14'h0000, PASS);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      wr_abs(vecs[i].we, vecs[i].wadr, vecs[i].wdata);
      rd($sformatf("vec%0d", i), vecs[i].radr, vecs[i].exp);
    end

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ---- on/off with one-edge output latency ----
    wr(14'd0, 16'h0001);
    wr(14'd5, 16'h0001);
    chk_led("on_latency", 3'b111);
    @(negedge clk);
    chk_led("on", 3'b101);
    wr(14'd5, 16'h0000);
    chk_led("off_latency", 3'b101);
    @(negedge clk);
    chk_led("off", 3'b111);

    // ---- PWM, duty 64 of 256, PRESCALE=0 (every cycle is a tick) ----
    wr(14'd4, 16'h4002);
    wr(14'd0, 16'h0003);                       // EN + CLR, also a tick cycle
    rd("clr_in_tick", BASE + 14'd2, 16'h0001); // pcnt=0, ch0 lit
    for (int n = 1; n <= 65; n++) begin
      @(negedge clk);
      if (n == 64) chk_led("pwm_last_on", 3'b110);
      if (n == 65) chk_led("pwm_first_off", 3'b111);
    end
    cnt = 0;
    for (int n = 0; n < 512; n++) begin
      @(negedge clk);
      if (!led_out[0]) cnt++;
    end
    chk16("pwm_duty64", 16'(cnt), 16'd128);

    wr(14'd4, 16'h0002);
    @(negedge clk);
    cnt = 0;
    for (int n = 0; n < 256; n++) begin
      @(negedge clk);
      if (!led_out[0]) cnt++;
    end
    chk16("pwm_duty0", 16'(cnt), 16'd0);

    // ---- asynchronous reset in the middle of PWM ----
    wr(14'd4, 16'h4002);
    wr(14'd5, 16'h0001);
    wr(14'd0, 16'h0003);
    repeat (5) @(negedge clk);
    chk_led("pre_rst_led", 3'b100);
    #2 rst = 1'b1;
    #1;
    chk_led("rst_async_led", 3'b111);
    rd("rst_ctrl", BASE + 14'd0, 16'h0000);
    rd("rst_prescale", BASE + 14'd1, 16'h0000);
    rd("rst_status", BASE + 14'd2, 16'h0000);
    rd("rst_cfg0", BASE + 14'd4, 16'h0000);
    rd("rst_cfg1", BASE + 14'd5, 16'h0000);
    rd("rst_cfg2", BASE + 14'd6, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ---- blink: PRESCALE=1, DUTY=2 -> toggle every 3*256*2 = 1536 clk ----
    wr(14'd1, 16'h0001);
    wr(14'd6, 16'h0203);
    wr(14'd0, 16'h0003);
    repeat (1536) @(negedge clk);
    chk_led("blink_before", 3'b111);
    @(negedge clk);
    chk_led("blink_on", 3'b011);
    repeat (1535) @(negedge clk);
    chk_led("blink_hold", 3'b011);
    @(negedge clk);
    chk_led("blink_off", 3'b111);

    // ---- PRESCALE lowered below the running count ticks next cycle ----
    wr(14'd1, 16'd100);
    wr(14'd0, 16'h0003);
    repeat (50) @(negedge clk);                 // pre_cnt = 50
    wr(14'd1, 16'd10);
    rd("pre_no_tick", BASE + 14'd2, 16'h0000);
    @(negedge clk);
    rd("pre_tick", BASE + 14'd2, 16'h0100);
    @(negedge clk);
    rd("pre_hold", BASE + 14'd2, 16'h0100);

    // ---- EN=0 darkens outputs and freezes counters ----
    wr(14'd1, 16'h0000);
    wr(14'd6, 16'h0000);
    wr(14'd5, 16'h0001);
    wr(14'd0, 16'h0003);
    repeat (9) @(negedge clk);
    wr(14'd0, 16'h0000);                        // last tick still counts: pcnt=10
    chk_led("en_last_on", 3'b101);
    rd("en0_status", BASE + 14'd2, 16'h0A00);
    @(negedge clk);
    chk_led("en0_dark", 3'b111);
    repeat (20) @(negedge clk);
    rd("en0_frozen", BASE + 14'd2, 16'h0A00);
    chk_led("en0_still_dark", 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
